// File: rtl/jk_mon_pkg.sv
// Shared definitions for the JK toggle monitor slice.
// Holds the monitor FSM state encoding and the default counter widths.
// No logic; imported by the monitor top.
package jk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } mon_state_t;

    localparam int CNT_W_DEF     = 8;
    localparam int LEN_W_DEF     = 8;
    localparam int STUCK_CYC_DEF = 16;

endpackage

// File: rtl/jk_edge_det.sv
// Samples the JK q level and flags 0->1 / 1->0 transitions.
// Latency: flags appear one edge after the new level reaches s (q_in->s is 1 edge, 2 with JK_MON_SYNC_EN).
// Backpressure: none; free-running pipeline, every clock produces a result.
//
// Ports: clk/rst (async active-high), q_in (raw q), e_rise/e_fall (registered
// transition flags), e_lvl (level the flags refer to), e_vld (e_lvl holds a real
// sample taken after reset). Macro JK_MON_SYNC_EN adds a synchronizer stage.
module jk_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic q_in,
    output logic e_rise,
    output logic e_fall,
    output logic e_lvl,
    output logic e_vld
);

    logic src;
    logic src_v;
    logic s;
    logic sv;
    logic p;

`ifdef JK_MON_SYNC_EN
    // sync_q and s form the two-flop synchronizer; s doubles as the sample
    // register, so enabling it costs exactly one extra edge of latency.
    logic sync_q;
    logic sync_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b0;
            sync_v <= 1'b0;
        end else begin
            sync_q <= q_in;
            sync_v <= 1'b1;
        end
    end

    assign src   = sync_q;
    assign src_v = sync_v;
`else
    assign src   = q_in;
    assign src_v = 1'b1;
`endif

    // sv marks that s holds a genuine sample rather than its reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s      <= 1'b0;
            sv     <= 1'b0;
            p      <= 1'b0;
            e_rise <= 1'b0;
            e_fall <= 1'b0;
            e_lvl  <= 1'b0;
            e_vld  <= 1'b0;
        end else begin
            s      <= src;
            sv     <= src_v;
            p      <= s;
            e_rise <= s & ~p;
            e_fall <= ~s & p;
            e_lvl  <= s;
            e_vld  <= sv;
        end
    end

endmodule

// File: rtl/jk_toggle_monitor.sv
// Monitors the JK flip-flop q: edge pulses, toggle count, high-period length, stuck flag.
// Latency: rise/fall 2 edges after q_in is first sampled (3 with JK_MON_SYNC_EN); all outputs registered.
// Backpressure: none; observes every cycle, counters saturate instead of stalling.
//
// Ports: clk, rst (async active-high), q_in, clr (sync clear of counters/flags),
// rise/fall pulses, toggle_cnt + sticky cnt_ovf, high_len + len_valid pulse,
// stuck level. Macro JK_MON_SYNC_EN enables the input synchronizer.
module jk_toggle_monitor
    import jk_mon_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int STUCK_CYC = STUCK_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             clr,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             cnt_ovf,
    output logic [LEN_W-1:0] high_len,
    output logic             len_valid,
    output logic             stuck
);

    localparam int                IDLE_W    = $clog2(STUCK_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0]  LEN_MAX   = {LEN_W{1'b1}};
    localparam logic [IDLE_W-1:0] STUCK_LIM = IDLE_W'(STUCK_CYC);

    logic e_rise;
    logic e_fall;
    logic e_lvl;
    logic e_vld;

    jk_edge_det u_edge_det (
        .clk    (clk),
        .rst    (rst),
        .q_in   (q_in),
        .e_rise (e_rise),
        .e_fall (e_fall),
        .e_lvl  (e_lvl),
        .e_vld  (e_vld)
    );

    mon_state_t state;
    mon_state_t state_nxt;

    logic [LEN_W-1:0]  hcnt;
    logic              hcnt_ok;
    logic [IDLE_W-1:0] idle_cnt;

    logic              rise_nxt;
    logic              fall_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ovf_nxt;
    logic [LEN_W-1:0]  hlen_nxt;
    logic              lv_nxt;
    logic              stuck_nxt;
    logic [LEN_W-1:0]  hcnt_nxt;
    logic              hcnt_ok_nxt;
    logic [IDLE_W-1:0] idle_nxt;

    // Edge flags are only meaningful against the level the FSM believes in;
    // in IDLE the first valid sample just establishes that level.
    logic is_rise;
    logic is_fall;

    assign is_rise = (state == ST_LOW)  && e_rise;
    assign is_fall = (state == ST_HIGH) && e_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (e_vld)   state_nxt = e_lvl ? ST_HIGH : ST_LOW;
                ST_LOW:  if (e_rise)  state_nxt = ST_HIGH;
                ST_HIGH: if (e_fall)  state_nxt = ST_LOW;
                default:              state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rise_nxt    = 1'b0;
        fall_nxt    = 1'b0;
        lv_nxt      = 1'b0;
        cnt_nxt     = toggle_cnt;
        ovf_nxt     = cnt_ovf;
        hlen_nxt    = high_len;
        stuck_nxt   = stuck;
        hcnt_nxt    = hcnt;
        hcnt_ok_nxt = hcnt_ok;
        idle_nxt    = idle_cnt;
        if (clr) begin
            // high_len survives a clear; an open high period is abandoned.
            cnt_nxt     = '0;
            ovf_nxt     = 1'b0;
            stuck_nxt   = 1'b0;
            idle_nxt    = '0;
            hcnt_ok_nxt = 1'b0;
        end else if (state == ST_IDLE) begin
            idle_nxt    = '0;
            hcnt_nxt    = '0;
            hcnt_ok_nxt = 1'b0;
        end else if (is_rise || is_fall) begin
            rise_nxt  = is_rise;
            fall_nxt  = is_fall;
            idle_nxt  = '0;
            stuck_nxt = 1'b0;
            if (toggle_cnt == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = toggle_cnt + 1'b1;
            end
            if (is_rise) begin
                hcnt_nxt    = {{(LEN_W-1){1'b0}}, 1'b1};
                hcnt_ok_nxt = 1'b1;
            end else begin
                // Only a high period that began with a reported rise is complete.
                if (hcnt_ok) begin
                    hlen_nxt = hcnt;
                    lv_nxt   = 1'b1;
                end
                hcnt_ok_nxt = 1'b0;
            end
        end else begin
            if ((state == ST_HIGH) && (hcnt != LEN_MAX)) begin
                hcnt_nxt = hcnt + 1'b1;
            end
            if (idle_cnt != STUCK_LIM) begin
                idle_nxt = idle_cnt + 1'b1;
            end
            stuck_nxt = (idle_nxt == STUCK_LIM);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise       <= 1'b0;
            fall       <= 1'b0;
            toggle_cnt <= '0;
            cnt_ovf    <= 1'b0;
            high_len   <= '0;
            len_valid  <= 1'b0;
            stuck      <= 1'b0;
            hcnt       <= '0;
            hcnt_ok    <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            rise       <= rise_nxt;
            fall       <= fall_nxt;
            toggle_cnt <= cnt_nxt;
            cnt_ovf    <= ovf_nxt;
            high_len   <= hlen_nxt;
            len_valid  <= lv_nxt;
            stuck      <= stuck_nxt;
            hcnt       <= hcnt_nxt;
            hcnt_ok    <= hcnt_ok_nxt;
            idle_cnt   <= idle_nxt;
        end
    end

endmodule

// File: tb/tb_jk_toggle_monitor.sv
// Bench for jk_toggle_monitor: directed scenarios with literal expectations,
// then randomized q_in/clr/rst traffic, all checked every cycle against a
// behavioural model of the monitor's observable rules.
module tb_jk_toggle_monitor;

`ifdef JK_MON_SYNC_EN
    localparam int L = 3;
`else
    localparam int L = 2;
`endif
    localparam int CW   = 3;
    localparam int LW   = 4;
    localparam int STK  = 16;
    localparam int CMAX = (1 << CW) - 1;
    localparam int LMAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          q_in = 1'b0;
    logic          clr = 1'b0;
    logic          rise;
    logic          fall;
    logic [CW-1:0] toggle_cnt;
    logic          cnt_ovf;
    logic [LW-1:0] high_len;
    logic          len_valid;
    logic          stuck;

    int checks = 0;
    int errors = 0;

    jk_toggle_monitor #(.CNT_W(CW), .LEN_W(LW), .STUCK_CYC(STK)) dut (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .clr        (clr),
        .rise       (rise),
        .fall       (fall),
        .toggle_cnt (toggle_cnt),
        .cnt_ovf    (cnt_ovf),
        .high_len   (high_len),
        .len_valid  (len_valid),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Works in "output time": the output after a clock edge reflects the
    // q_in level sampled L edges earlier; clr acts on the current edge.
    bit hist[$];
    bit m_act, m_lvl, m_hok, m_r, m_f, m_lv, m_stk, m_ovf;
    int m_hcnt, m_cnt, m_hlen, m_idle;

    initial begin
        bit y;
        bit yv;
        forever begin
            @(posedge clk);
            if (rst) begin
                hist.delete();
                m_act = 0; m_lvl = 0; m_hok = 0; m_r = 0; m_f = 0; m_lv = 0;
                m_stk = 0; m_ovf = 0; m_hcnt = 0; m_cnt = 0; m_hlen = 0; m_idle = 0;
            end else begin
                hist.push_back(q_in);
                yv = (hist.size() > L);
                y  = yv ? hist[hist.size() - 1 - L] : 1'b0;
                if (hist.size() > 8) void'(hist.pop_front());
                m_r = 0; m_f = 0; m_lv = 0;
                if (clr) begin
                    m_act = 0; m_cnt = 0; m_ovf = 0; m_stk = 0; m_idle = 0; m_hok = 0;
                end else if (!m_act) begin
                    if (yv) begin
                        m_act = 1; m_lvl = y; m_idle = 0; m_hok = 0; m_hcnt = 0;
                    end
                end else if (y != m_lvl) begin
                    if (m_cnt == CMAX) m_ovf = 1; else m_cnt++;
                    if (y) begin
                        m_r = 1; m_hcnt = 1; m_hok = 1;
                    end else begin
                        m_f = 1;
                        if (m_hok) begin m_hlen = m_hcnt; m_lv = 1; end
                        m_hok = 0;
                    end
                    m_lvl = y; m_idle = 0; m_stk = 0;
                end else begin
                    if (m_lvl && m_hcnt < LMAX) m_hcnt++;
                    if (m_idle < STK) m_idle++;
                    if (m_idle >= STK) m_stk = 1;
                end
            end
            #1;
            chk("m_rise",      int'(rise),       int'(m_r));
            chk("m_fall",      int'(fall),       int'(m_f));
            chk("m_toggle",    int'(toggle_cnt), m_cnt);
            chk("m_ovf",       int'(cnt_ovf),    int'(m_ovf));
            chk("m_high_len",  int'(high_len),   m_hlen);
            chk("m_len_valid", int'(len_valid),  int'(m_lv));
            chk("m_stuck",     int'(stuck),      int'(m_stk));
        end
    end

    // ---------------- stimulus + literal expectations ----------------
    task automatic wait_pulse(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (rise || fall) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rise"},   int'(rise),       0);
        chk({tag, "_fall"},   int'(fall),       0);
        chk({tag, "_cnt"},    int'(toggle_cnt), 0);
        chk({tag, "_ovf"},    int'(cnt_ovf),    0);
        chk({tag, "_hlen"},   int'(high_len),   0);
        chk({tag, "_lv"},     int'(len_valid),  0);
        chk({tag, "_stuck"},  int'(stuck),      0);
    endtask

    initial begin
        int c;
        int spur;
        bit lvl;
        int len;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");

        // Constant low long enough to go stuck.
        rst = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        chk("stuck_after_constant", int'(stuck), 1);
        chk("no_edges_yet", int'(toggle_cnt), 0);

        // Five-cycle high period with latency measurement.
        @(negedge clk) q_in = 1'b1;
        wait_pulse(c);
        chk("rise_latency", c, L + 1);
        chk("rise_pulse", int'(rise), 1);
        chk("stuck_clear_on_rise", int'(stuck), 0);
        repeat (5 - c) @(posedge clk);
        @(negedge clk) q_in = 1'b0;
        wait_pulse(c);
        chk("fall_latency", c, L + 1);
        chk("fall_pulse", int'(fall), 1);
        chk("len_valid_with_fall", int'(len_valid), 1);
        chk("high_len_5", int'(high_len), 5);
        chk("toggle_cnt_2", int'(toggle_cnt), 2);
        @(posedge clk);
        #1;
        chk("len_valid_one_cycle", int'(len_valid), 0);

        // Reset in the middle of a high period.
        repeat (3) @(negedge clk);
        q_in = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        spur = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (rise || fall) spur++;
        end
        chk("no_spurious_after_rst", spur, 0);
        @(negedge clk) q_in = 1'b0;
        wait_pulse(c);
        chk("fall_after_rst_latency", c, L + 1);
        chk("truncated_high_no_len_valid", int'(len_valid), 0);
        chk("toggle_after_rst", int'(toggle_cnt), 1);

        // Short high period, then clr coincident with the next rise.
        @(negedge clk) q_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) q_in = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("high_len_3", int'(high_len), 3);
        @(negedge clk) q_in = 1'b1;
        repeat (L) @(posedge clk);
        @(negedge clk) clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_rise_suppressed", int'(rise), 0);
        chk("clr_toggle_zero", int'(toggle_cnt), 0);
        chk("clr_high_len_kept", int'(high_len), 3);
        @(negedge clk) clr = 1'b0;
        spur = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rise) spur++;
        end
        chk("no_late_rise_after_clr", spur, 0);

        // Counter saturation: nine edges with a 3-bit counter.
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk) q_in = ~q_in;
            wait_pulse(c);
            chk("sat_edge_seen", int'(c != 0), 1);
            if (e == 7) begin
                chk("sat_cnt_at_7", int'(toggle_cnt), 7);
                chk("sat_no_ovf_at_7", int'(cnt_ovf), 0);
            end
            if (e == 8) chk("sat_ovf_at_8", int'(cnt_ovf), 1);
            if (e == 9) begin
                chk("sat_cnt_held", int'(toggle_cnt), 7);
                chk("sat_ovf_sticky", int'(cnt_ovf), 1);
            end
        end

        // Randomized traffic: run lengths span short pulses, LEN_W
        // saturation and stuck; occasional clr and reset.
        lvl = q_in;
        for (int k = 0; k < 200; k++) begin
            len = $urandom_range(1, 24);
            lvl = ~lvl;
            for (int j = 0; j < len; j++) begin
                @(negedge clk);
                q_in = lvl;
                clr  = ($urandom_range(0, 63) == 0);
                rst  = ($urandom_range(0, 399) == 0);
            end
        end
        @(negedge clk);
        clr = 1'b0;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_toggle_monitor.md
JK_TOGGLE_MONITOR -- requirements
Module: jk_toggle_monitor
Purpose: downstream stage of the JK flip-flop; consumes its q output; reports edges, toggle count, high-time and stuck condition.

Interface
REQ-001 SHALL have parameter CNT_W, default 8: toggle counter width.
REQ-002 SHALL have parameter LEN_W, default 8: high-period length width.
REQ-003 SHALL have parameter STUCK_CYC, default 16: cycles without an edge before stuck asserts.
REQ-004 SHALL have port clk  input  1: single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port q_in  input  1: q from JK flip-flop.
REQ-007 SHALL have port clr  input  1: synchronous clear of counters and flags.
REQ-008 SHALL have port rise  output  1: one-cycle pulse per detected 0->1.
REQ-009 SHALL have port fall  output  1: one-cycle pulse per detected 1->0.
REQ-010 SHALL have port toggle_cnt  output  CNT_W: edges counted since reset/clr.
REQ-011 SHALL have port cnt_ovf  output  1: sticky; set when an edge arrives with toggle_cnt at max.
REQ-012 SHALL have port high_len  output  LEN_W: clock count of last completed high period.
REQ-013 SHALL have port len_valid  output  1: one-cycle pulse when high_len updates.
REQ-014 SHALL have port stuck  output  1: level; no edge for STUCK_CYC cycles.

Function
REQ-015 SHALL sample q_in into a sample register s and keep its previous value p; edge = s differs from p.
REQ-016 SHALL run FSM IDLE, LOW, HIGH; IDLE -> LOW/HIGH on first sample after reset/clr per s, with no edge reported.
REQ-017 SHALL in LOW move to HIGH on rise, in HIGH move to LOW on fall; no other transitions except reset/clr -> IDLE.
REQ-018 SHALL register all outputs; rise/fall asserted 2 clk edges after the edge that first samples new q_in level (3 with synchronizer, REQ-030).
REQ-019 SHALL increment toggle_cnt by 1 per rise or fall; saturate at 2^CNT_W-1; then set cnt_ovf.
REQ-020 SHALL count cycles in HIGH starting at 1 on the rise cycle, saturating at 2^LEN_W-1.
REQ-021 SHALL on fall load high_len with that count and pulse len_valid in the same cycle as fall.
REQ-022 SHALL count cycles since last edge (or since leaving IDLE); assert stuck when count reaches STUCK_CYC; hold until next edge.
REQ-023 SHALL deassert stuck in the same cycle the next rise/fall pulse is output.
REQ-024 SHALL give clr priority over a simultaneous edge: edge not counted, no pulse, FSM -> IDLE.
REQ-025 SHALL keep high_len unchanged across clr; clr zeroes toggle_cnt, cnt_ovf, stuck, idle counter.
REQ-026 SHALL ignore a high period truncated by clr or reset (no len_valid).

Reset
REQ-027 SHALL on rst asynchronously force FSM IDLE; rise, fall, len_valid, stuck, cnt_ovf = 0; toggle_cnt = 0; high_len = 0; sample/sync registers = 0.
REQ-028 SHALL resume from IDLE on the first clk after rst deasserts; reset mid-high-period discards it.

Configuration
REQ-029 SHALL support macro JK_MON_SYNC_EN.
REQ-030 SHALL with JK_MON_SYNC_EN defined insert a 2-flop synchronizer before s (rise/fall latency 3 edges).
REQ-031 SHALL without JK_MON_SYNC_EN sample q_in directly into s (latency 2 edges); all else identical.

Structure
REQ-032 SHALL place FSM state encoding (IDLE, LOW, HIGH) and default widths in shared package jk_mon_pkg.
REQ-033 SHALL implement edge detection (sync, s, p) as sub-module jk_edge_det; counters/FSM in top.

Verification
REQ-034 SHALL test reset: rst=1 mid-run -> all outputs 0 immediately, FSM IDLE; release -> no spurious rise/fall.
REQ-035 SHALL test high period: q_in high 5 cycles then low -> one rise, one fall, high_len=5, len_valid 1 cycle, toggle_cnt=2.
REQ-036 SHALL test saturation: CNT_W=3, 9 edges -> toggle_cnt=7, cnt_ovf=1 from the 8th edge.
REQ-037 SHALL test stuck: q_in constant 16 cycles -> stuck=1; then toggle -> stuck=0 with rise pulse.
REQ-038 SHALL test clr coincident with rise -> no rise pulse, toggle_cnt=0, high_len kept.
REQ-039 SHALL run all tests with and without JK_MON_SYNC_EN, checking latency 3 vs 2.
